// File: rtl/riscv_pkg.sv
// Shared encodings and widths for the RV32IM pipeline.
// Every select/operation field used by the execute stage is named here.
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110,
    BR_RSVD = 3'b111
  } branch_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JAL  = 2'b01,
    JMP_JALR = 2'b10,
    JMP_RSVD = 2'b11
  } jump_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;
endpackage

// File: rtl/md_unit.sv
// Iterative RV32M unit: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, sign-corrected when the result is presented in DONE.
module md_unit #(
  parameter int W    = 32,
  parameter int ITER = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);
  import riscv_pkg::*;

  localparam int CW = $clog2(ITER);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  md_state_e       state;
  logic [CW-1:0]   count;
  md_op_e          op_q;
  logic [W-1:0]    b_q;
  logic [2*W-1:0]  acc;
  logic            neg_q;
  logic            neg_r;

  md_op_e          op_e;
  logic            a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  assign op_e     = md_op_e'(op);
  assign a_neg    = a[W-1] & (op_e inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign b_neg    = b[W-1] & (op_e inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign is_div   = op[2];
  assign div_zero = is_div & (b == '0);
  assign div_ovf  = (op_e inside {MD_DIV, MD_REM}) & (a == MIN_NEG) & (b == '1);

  // acc holds {hi, lo}: product/multiplier for mul, remainder/quotient for div.
  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  assign busy = ((state == MD_IDLE) & start) | (state == MD_BUSY);
  assign done = (state == MD_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      count <= '0;
      op_q  <= MD_MUL;
      b_q   <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q  <= op_e;
            count <= '0;
            b_q   <= b_mag;
            if (div_zero) begin
              acc   <= {a, {W{1'b1}}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= MD_DONE;
            end else if (div_ovf) begin
              acc   <= {{W{1'b0}}, MIN_NEG};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= MD_DONE;
            end else begin
              acc   <= {{W{1'b0}}, a_mag};
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (flush) begin
            state <= MD_IDLE;
          end else begin
            if (op_q[2]) begin
              if (!div_diff[W]) acc <= {div_diff[W-1:0], acc[W-2:0], 1'b1};
              else              acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
            end else begin
              acc <= {mul_sum, acc[W-1:1]};
            end
            count <= count + 1'b1;
            if (count == CW'(ITER - 1)) state <= MD_DONE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_comb begin
    result = '0;
    case (op_q)
      MD_MUL:               result = prod_fix[W-1:0];
      MD_MULH, MD_MULHSU,
      MD_MULHU:             result = prod_fix[2*W-1:W];
      MD_DIV, MD_DIVU:      result = quo_fix;
      default:              result = rem_fix;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch/jump resolution
// and the result mux in front of the EX/MEM register.
module ex_stage #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int MD_ITER = riscv_pkg::MD_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flushE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] extImmE,
  input  logic [2:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic [2:0]      branchE,
  input  logic [1:0]      jumpE,
  input  logic            mdEnE,
  input  logic [2:0]      mdOpE,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] writeDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE,
  output logic            stallMD
);
  import riscv_pkg::*;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_out, md_result, jalr_sum;
  logic            taken, is_jump, md_busy, md_done;

  always_comb begin
    case (fwd_e'(forwardAE))
      FWD_W:   src_a = resultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (fwd_e'(forwardBE))
      FWD_W:   fwd_b = resultW;
      FWD_M:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b      = ALUSrcE ? extImmE : fwd_b;
  assign writeDataE = fwd_b;

  always_comb begin
    case (alu_op_e'(ALUControlE))
      ALU_ADD: alu_out = src_a + src_b;
      ALU_SUB: alu_out = src_a - src_b;
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_XOR: alu_out = src_a ^ src_b;
      ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLL: alu_out = src_a << src_b[4:0];
      default: alu_out = src_a >> src_b[4:0];
    endcase
  end

  always_comb begin
    case (branch_e'(branchE))
      BR_BEQ:  taken = (src_a == fwd_b);
      BR_BNE:  taken = (src_a != fwd_b);
      BR_BLT:  taken = ($signed(src_a) < $signed(fwd_b));
      BR_BGE:  taken = ($signed(src_a) >= $signed(fwd_b));
      BR_BLTU: taken = (src_a < fwd_b);
      BR_BGEU: taken = (src_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign is_jump   = (jump_e'(jumpE) == JMP_JAL) | (jump_e'(jumpE) == JMP_JALR);
  assign jalr_sum  = src_a + extImmE;
  assign PCTargetE = (jump_e'(jumpE) == JMP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : PCE + extImmE;
  // No redirect while the M-unit holds the stage or the instruction is being killed.
  assign PCSrcE    = (taken | is_jump) & ~stallMD & ~flushE;

  md_unit #(.W(XLEN), .ITER(MD_ITER)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (mdEnE & ~flushE),
    .flush  (flushE),
    .op     (mdOpE),
    .a      (src_a),
    .b      (fwd_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign stallMD = md_busy;

  always_comb begin
    if (is_jump)      ALUResultE = PCPlus4E;
    else if (md_done) ALUResultE = md_result;
    else              ALUResultE = alu_out;
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU, branches, jumps and the
// iterative M-unit including special cases, reset and flush aborts.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        flushE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, extImmE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [2:0]  branchE;
  logic [1:0]  jumpE;
  logic        mdEnE;
  logic [2:0]  mdOpE;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] ALUResultM, resultW;
  logic [31:0] ALUResultE, writeDataE, PCTargetE;
  logic        PCSrcE, stallMD;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flushE      (flushE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .extImmE     (extImmE),
    .ALUControlE (ALUControlE),
    .ALUSrcE     (ALUSrcE),
    .branchE     (branchE),
    .jumpE       (jumpE),
    .mdEnE       (mdEnE),
    .mdOpE       (mdOpE),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .ALUResultM  (ALUResultM),
    .resultW     (resultW),
    .ALUResultE  (ALUResultE),
    .writeDataE  (writeDataE),
    .PCTargetE   (PCTargetE),
    .PCSrcE      (PCSrcE),
    .stallMD     (stallMD)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    flushE = 0; RD1E = 0; RD2E = 0; PCE = 0; PCPlus4E = 0; extImmE = 0;
    ALUControlE = 0; ALUSrcE = 0; branchE = 0; jumpE = 0; mdEnE = 0; mdOpE = 0;
    forwardAE = 0; forwardBE = 0; ALUResultM = 0; resultW = 0;
  endtask

  // Launch an M op, scramble the forward sources every stall cycle, then
  // check the stall length and the presented result.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
    int cyc;
    @(negedge clk);
    clear_inputs();
    mdEnE = 1; mdOpE = op; RD1E = a; RD2E = b;
    #1;
    cyc = 0;
    while (stallMD && cyc < 100) begin
      cyc++;
      @(negedge clk);
      RD1E = $urandom; RD2E = $urandom; ALUResultM = $urandom; resultW = $urandom;
      forwardAE = 2'($urandom_range(0, 3)); forwardBE = 2'($urandom_range(0, 3));
      #1;
    end
    chk({tag, "_stall_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_result"}, ALUResultE, exp_res);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    chk("reset_stall", {31'b0, stallMD}, 32'd0);
    chk("reset_pcsrc", {31'b0, PCSrcE}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;

    // forwarding
    @(negedge clk);
    RD1E = 1; ALUResultM = 5; forwardAE = 2'b10; RD2E = 3; ALUControlE = 3'b000;
    #1 chk("fwd_a_mem", ALUResultE, 32'd8);
    forwardAE = 2'b01; resultW = 9;
    #1 chk("fwd_a_wb", ALUResultE, 32'd12);
    forwardBE = 2'b11;
    #1 chk("fwd_b_11_is_rf", writeDataE, 32'd3);
    forwardBE = 2'b10;
    #1 chk("fwd_b_mem_store", writeDataE, 32'd5);

    // ALU
    @(negedge clk);
    clear_inputs();
    RD1E = 1; RD2E = 3; ALUControlE = 3'b001;
    #1 chk("alu_sub_wrap", ALUResultE, 32'hFFFFFFFE);
    RD1E = 32'hFFFFFFF0; RD2E = 1; ALUControlE = 3'b101;
    #1 chk("alu_slt_signed", ALUResultE, 32'd1);
    ALUSrcE = 1; extImmE = 4; ALUControlE = 3'b111;
    #1 chk("alu_srl_imm", ALUResultE, 32'h0FFFFFFF);
    RD1E = 3; extImmE = 32'h21; ALUControlE = 3'b110;
    #1 chk("alu_sll_shamt5", ALUResultE, 32'd6);

    // branches
    @(negedge clk);
    clear_inputs();
    RD1E = 32'hFFFFFFFF; RD2E = 1; PCE = 32'h100; extImmE = 32'h20; branchE = 3'b011;
    #1 chk("blt_taken", {31'b0, PCSrcE}, 32'd1);
    chk("branch_target", PCTargetE, 32'h120);
    branchE = 3'b101;
    #1 chk("bltu_not_taken", {31'b0, PCSrcE}, 32'd0);

    // jalr
    @(negedge clk);
    clear_inputs();
    RD1E = 32'h1003; extImmE = 4; PCE = 32'h2000; PCPlus4E = 32'h2004; jumpE = 2'b10;
    #1 chk("jalr_target", PCTargetE, 32'h1006);
    chk("jalr_link", ALUResultE, 32'h2004);
    chk("jalr_pcsrc", {31'b0, PCSrcE}, 32'd1);
    flushE = 1;
    #1 chk("jalr_flushed", {31'b0, PCSrcE}, 32'd0);

    // M-unit normal ops and special cases
    run_md("div_neg7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_md("rem_neg7_2",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_md("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_md("mul_neg2_3",  3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 33);
    run_md("mulh_neg2_3", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33);
    run_md("mulhsu_m1_2", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    run_md("divu_by0",    3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
    run_md("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("rem_by0",     3'b110, 32'd13, 32'd0, 32'd13, 1);

    // async reset mid-operation
    @(negedge clk);
    clear_inputs();
    mdEnE = 1; mdOpE = 3'b100; RD1E = 100; RD2E = 7;
    repeat (10) @(negedge clk);
    #1 chk("busy_before_rst", {31'b0, stallMD}, 32'd1);
    #1 rst = 1; mdEnE = 0;
    #1 chk("rst_clears_stall", {31'b0, stallMD}, 32'd0);
    @(negedge clk);
    rst = 0;

    // flush mid-operation
    @(negedge clk);
    mdEnE = 1; mdOpE = 3'b101; RD1E = 100; RD2E = 7;
    repeat (10) @(negedge clk);
    flushE = 1;
    #1 chk("busy_at_flush", {31'b0, stallMD}, 32'd1);
    @(negedge clk);
    flushE = 0; mdEnE = 0;
    #1 chk("flush_to_idle", {31'b0, stallMD}, 32'd0);

    run_md("mul_6_7_after_abort", 3'b000, 32'd6, 32'd7, 32'd42, 33);

    @(negedge clk);
    clear_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline. It sits directly downstream of the ID/EX register and feeds the EX/MEM register.
- It performs operand forwarding, the single-cycle ALU, branch/jump resolution and target generation.
- It also contains an iterative multiply/divide unit (RV32M) that holds the pipeline via a stall request while it runs.

Parameters:
- XLEN, 32, datapath width.
- MD_ITER, 32, multiply/divide iterations (one bit per cycle).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- flushE  in  1  synchronous abort of the EX-stage instruction (same cycle as ID/EX clr).
- RD1E, RD2E  in  32 each  register operands from ID/EX.
- PCE, PCPlus4E, extImmE  in  32 each  from ID/EX.
- ALUControlE  in  3  ALU operation.
- ALUSrcE  in  1  1 selects extImmE as operand B.
- branchE  in  3  branch type.
- jumpE  in  2  jump type.
- mdEnE  in  1  instruction is an RV32M operation.
- mdOpE  in  3  M-operation select.
- forwardAE, forwardBE  in  2 each  00 register file, 01 resultW, 10 ALUResultM.
- ALUResultM  in  32  MEM-stage forward source.
- resultW  in  32  WB-stage forward source.
- ALUResultE  out  32  ALU or M-unit result.
- writeDataE  out  32  forwarded operand B, before the ALUSrc mux (store data).
- PCTargetE  out  32  branch/jump target.
- PCSrcE  out  1  redirect fetch to PCTargetE.
- stallMD  out  1  stall request for F, D and E; ID/EX must hold while it is high.

Behaviour:
- Reset state: FSM in IDLE, iteration counter 0, operand latches 0, stallMD 0. All other outputs are combinational from inputs.
- Forwarding: srcA = mux(forwardAE). fwdB = mux(forwardBE). forwardXE=11 is treated as 00. srcB = ALUSrcE ? extImmE : fwdB.
- ALUControlE encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl. Shift amount is srcB[4:0]. All arithmetic is modulo 2^32.
- branchE encoding: 000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu. Comparisons use srcA vs fwdB.
- jumpE encoding: 00 none, 01 jal, 10 jalr, 11 treated as none.
- PCTargetE: jalr gives (srcA+extImmE) & ~1; otherwise PCE+extImmE.
- PCSrcE = (branch taken | jumpE∈{01,10}) & ~stallMD & ~flushE.
- On any jump, ALUResultE = PCPlus4E (link value).
- mdOpE encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- M-unit FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If mdEnE & ~flushE: stallMD=1 combinationally in this same cycle.
  - At the edge, latch srcA, fwdB and mdOpE, convert operands to magnitude per signedness, counter←0.
  - Next state is BUSY, or DONE directly for a special case.
- BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle; stallMD=1. After MD_ITER steps the FSM goes to DONE.
- DONE: stallMD=0 and ALUResultE = sign-corrected M result. At the next edge the instruction advances and the FSM returns to IDLE, unconditionally. There is no restart even though mdEnE is still high in DONE.
- Latency: normal ops stall 1+MD_ITER = 33 cycles; the result is presented in cycle 34.
- Special cases resolve at start with a 1-cycle stall (IDLE→DONE):
  - divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - signed overflow 0x80000000 / -1: quotient = 0x80000000, remainder = 0.
- mul returns the low 32 bits; mulh, mulhsu and mulhu return the high 32 bits of the 64-bit product.
- While stallMD=1, the forward sources may change. The unit uses only latched operands.
- flushE in BUSY or DONE: FSM→IDLE at the next edge, result discarded.
- rst at any time: FSM→IDLE immediately.
- Non-M instructions never touch the FSM and add no latency.

Decomposition:
- Shared package riscv_pkg: ALUControl, branch, jump, mdOp and forward-select encodings; XLEN.
- Sub-module md_unit holds the FSM, counter, operand latches, iterative datapath and special-case detection. Its interface is start/op/a/b in, busy/done/result out.
- ex_stage holds the forwarding, ALU, branch logic and result mux.

Test Plan:
- Forwarding: RD1E=1, ALUResultM=5, forwardAE=10, RD2E=3, add → ALUResultE=8. Then forwardAE=01 with resultW=9 → 12.
- Branches: srcA=0xFFFFFFFF, fwdB=1, blt → PCSrcE=1. Same operands with bltu → PCSrcE=0. PCE=0x100, imm=0x20 → PCTargetE=0x120.
- jalr: srcA=0x1003, imm=4 → PCTargetE=0x1006, ALUResultE=PCPlus4E, PCSrcE=1.
- div: -7 / 2 → stallMD high exactly 33 cycles, then result 0xFFFFFFFD. rem -7,2 → 0xFFFFFFFF. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. Forward sources are changed mid-op and the results do not change.
- Special cases: divu x/0 → 0xFFFFFFFF after a 1-cycle stall. div 0x80000000/-1 → 0x80000000. rem by 0 with dividend 13 → 13.
- Abort: assert rst (async) at BUSY cycle 10 → stallMD=0 immediately. Assert flushE at BUSY cycle 10 → IDLE next edge. A new mul 6×7 afterwards → 42.
